// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time, registered bus request, byte/half extract and extend.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
`timescale 1ns/1ps
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_load,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic            resp_err
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [2:0] LOAD_BYTE          = 3'b000;
   localparam logic [2:0] LOAD_HALF          = 3'b001;
   localparam logic [2:0] LOAD_WORD          = 3'b010;
   localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
   localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;

   state_t          state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]      mem_be_q, mem_be_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] resp_data_q, resp_data_d;
   logic            resp_err_q, resp_err_d;
   logic [2:0]      ld_funct3_q, ld_funct3_d;
   logic [1:0]      ld_off_q, ld_off_d;

   logic            load_bad, store_bad, misalign, illegal;
   logic [1:0]      eff_off;

   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [XLEN-1:0] word);
      logic [XLEN-1:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         LOAD_BYTE:          return {{24{sh[7]}}, sh[7:0]};
         LOAD_HALF:          return {{16{sh[15]}}, sh[15:0]};
         LOAD_BYTE_UNSIGNED: return {24'h0, sh[7:0]};
         LOAD_HALF_UNSIGNED: return {16'h0, sh[15:0]};
         default:            return word;
      endcase
   endfunction

   always_comb begin
      load_bad  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
      store_bad = (req_funct3 >= 3'b011);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      misalign  = 1'b0;
`endif
      illegal   = (req_load == req_store) || (req_load ? load_bad : store_bad) || misalign;

      // Halfword/word offsets snap to natural alignment when misalignment is not trapped.
      case (req_funct3[1:0])
         2'b00:   eff_off = req_addr[1:0];
         2'b01:   eff_off = {req_addr[1], 1'b0};
         default: eff_off = 2'b00;
      endcase

      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      ld_funct3_d  = ld_funct3_q;
      ld_off_d     = ld_off_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (illegal) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_data_d  = '0;
               end else begin
                  state_d     = BUS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_store;
                  mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                  ld_funct3_d = req_funct3;
                  ld_off_d    = eff_off;
                  mem_be_d    = 4'b0000;
                  mem_wdata_d = '0;
                  if (req_store) begin
                     case (req_funct3[1:0])
                        2'b00: begin
                           mem_be_d    = 4'b0001 << eff_off;
                           mem_wdata_d = {4{req_wdata[7:0]}};
                        end
                        2'b01: begin
                           mem_be_d    = 4'b0011 << eff_off;
                           mem_wdata_d = {2{req_wdata[15:0]}};
                        end
                        default: begin
                           mem_be_d    = 4'b1111;
                           mem_wdata_d = req_wdata;
                        end
                     endcase
                  end
               end
            end
         end
         BUS: begin
            if (mem_ack) begin
               state_d      = RESP;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_data_d  = mem_we_q ? '0 : load_ext(ld_funct3_q, ld_off_q, mem_rdata);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= 4'b0000;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         ld_funct3_q  <= 3'b000;
         ld_off_q     <= 2'b00;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         ld_funct3_q  <= ld_funct3_d;
         ld_off_q     <= ld_off_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs change 1ns after the rising edge and are sampled there too.
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_load, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        resp_valid, resp_err;
   logic [31:0] resp_data;

   int total = 0;
   int bad   = 0;
   int pulses;

   load_store_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single edge; returns 1ns after the accepting edge.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      req_load = ld; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      #3;
      chk("rst_req_ready",  32'(req_ready), 32'h1);
      chk("rst_mem_req",    32'(mem_req), 32'h0);
      chk("rst_mem_be",     32'(mem_be), 32'h0);
      chk("rst_mem_addr",   mem_addr, 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_data",  resp_data, 32'h0);
      chk("rst_resp_err",   32'(resp_err), 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // mem_ack in IDLE must not produce a response
      mem_ack = 1'b1;
      step();
      chk("idle_ack_no_resp", 32'(resp_valid), 32'h0);
      chk("idle_ack_ready",   32'(req_ready), 32'h1);
      mem_ack = 1'b0;

      // LB 0x103, ack in first BUS cycle
      issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
      chk("lb_mem_req",   32'(mem_req), 32'h1);
      chk("lb_mem_addr",  mem_addr, 32'h100);
      chk("lb_mem_we",    32'(mem_we), 32'h0);
      chk("lb_mem_be",    32'(mem_be), 32'h0);
      chk("lb_ready_low", 32'(req_ready), 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
      step();
      mem_ack = 1'b0;
      chk("lb_resp_valid", 32'(resp_valid), 32'h1);
      chk("lb_resp_data",  resp_data, 32'hFFFF_FF80);
      chk("lb_resp_err",   32'(resp_err), 32'h0);
      chk("lb_mem_req_off", 32'(mem_req), 32'h0);
      step();
      chk("lb_resp_drop",  32'(resp_valid), 32'h0);
      chk("lb_data_hold",  resp_data, 32'hFFFF_FF80);
      chk("lb_ready_back", 32'(req_ready), 32'h1);

      // LHU 0x102 zero-extends the upper halfword
      issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
      step();
      mem_ack = 1'b0;
      chk("lhu_resp_data", resp_data, 32'h0000_80FF);
      step();

      // SH 0x202
      issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF);
      chk("sh_mem_be",    32'(mem_be), 32'hC);
      chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("sh_mem_we",    32'(mem_we), 32'h1);
      chk("sh_mem_addr",  mem_addr, 32'h200);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("sh_resp_valid", 32'(resp_valid), 32'h1);
      chk("sh_resp_data",  resp_data, 32'h0);
      chk("sh_resp_err",   32'(resp_err), 32'h0);
      step();

      // SB 0x001 replicates the low byte
      issue(1'b0, 1'b1, 3'b000, 32'h001, 32'h1234_5678);
      chk("sb_mem_be",    32'(mem_be), 32'h2);
      chk("sb_mem_wdata", mem_wdata, 32'h7878_7878);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();

      // LW 0x300, ack arrives in the sixth BUS cycle
      issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         chk("lw_wait_mem_req",  32'(mem_req), 32'h1);
         chk("lw_wait_mem_addr", mem_addr, 32'h300);
         chk("lw_wait_be",       32'(mem_be), 32'h0);
         chk("lw_wait_ready",    32'(req_ready), 32'h0);
         if (resp_valid) pulses++;
         step();
      end
      chk("lw_mem_req_c6", 32'(mem_req), 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ack = 1'b0;
      chk("lw_resp_data", resp_data, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         if (resp_valid) pulses++;
         step();
      end
      chk("lw_one_pulse", 32'(pulses), 32'h1);

      // LW 0x301 misaligned
      issue(1'b1, 1'b0, 3'b010, 32'h301, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_mem_req",    32'(mem_req), 32'h0);
      chk("mis_resp_valid", 32'(resp_valid), 32'h1);
      chk("mis_resp_err",   32'(resp_err), 32'h1);
      chk("mis_resp_data",  resp_data, 32'h0);
      step();
`else
      chk("mis_mem_req",  32'(mem_req), 32'h1);
      chk("mis_mem_addr", mem_addr, 32'h300);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      chk("mis_resp_valid", 32'(resp_valid), 32'h1);
      chk("mis_resp_err",   32'(resp_err), 32'h0);
      chk("mis_resp_data",  resp_data, 32'hCAFE_F00D);
      step();
`endif
      step();

      // Reset during the third BUS cycle
      issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
      step();
      step();
      chk("rstbus_mem_req_before", 32'(mem_req), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rstbus_mem_req",  32'(mem_req), 32'h0);
      chk("rstbus_mem_addr", mem_addr, 32'h0);
      chk("rstbus_ready",    32'(req_ready), 32'h1);
      chk("rstbus_resp_data", resp_data, 32'h0);
      step();
      rst_n = 1'b1;
      mem_ack = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (resp_valid) pulses++;
      end
      mem_ack = 1'b0;
      chk("rstbus_no_resp", 32'(pulses), 32'h0);
      issue(1'b1, 1'b0, 3'b000, 32'h000, 32'h0);
      chk("post_rst_mem_req", 32'(mem_req), 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'h0000_007F;
      step();
      mem_ack = 1'b0;
      chk("post_rst_resp", resp_data, 32'h0000_007F);
      step();

      // load and store both set
      issue(1'b1, 1'b1, 3'b010, 32'h500, 32'h0);
      chk("both_resp_valid", 32'(resp_valid), 32'h1);
      chk("both_resp_err",   32'(resp_err), 32'h1);
      chk("both_mem_req",    32'(mem_req), 32'h0);
      step();
      chk("both_resp_drop",  32'(resp_valid), 32'h0);
      chk("both_err_hold",   32'(resp_err), 32'h1);

      // load funct3 011
      issue(1'b1, 1'b0, 3'b011, 32'h600, 32'h0);
      chk("f3_resp_valid", 32'(resp_valid), 32'h1);
      chk("f3_resp_err",   32'(resp_err), 32'h1);
      chk("f3_resp_data",  resp_data, 32'h0);
      chk("f3_mem_req",    32'(mem_req), 32'h0);
      step();

      // store funct3 011
      issue(1'b0, 1'b1, 3'b011, 32'h700, 32'h0);
      chk("sf3_resp_err", 32'(resp_err), 32'h1);
      chk("sf3_mem_req",  32'(mem_req), 32'h0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
